// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset PC, chip-enable levels, FSM states.
package inst_fetch_pkg;

    localparam int          InstBus        = 32;
    localparam int          InstAddrBus    = 32;
    localparam logic [31:0] ResetPcDefault = 32'h1c000000;
    localparam logic [31:0] ZeroWord       = 32'h0;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Skid FIFO holding fetched {pc, inst} pairs; flush clears occupancy and pointers.
module inst_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage is cleared on reset so the head reads zero before anything is fetched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC generation, RAM read issue, 1-cycle capture into the skid FIFO, branch flush.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W    = InstAddrBus,
    parameter int                INST_W    = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(ResetPcDefault),
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              ram_ce_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic              ram_flush_o,
    input  logic [INST_W-1:0] ram_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_v;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic [OW-1:0]     occ;

    assign pop  = inst_valid_o & inst_ready_i;
    assign push = inflight_v & ~branch_flag_i;

    // Occupancy counts the in-flight read so the FIFO can always absorb it next cycle.
    assign occ   = OW'(fifo_count) + OW'(inflight_v) - OW'(pop);
    assign issue = (state == RUN) & ~branch_flag_i & (occ < OW'(BUF_DEPTH));

    assign ram_ce_o     = issue ? ChipEnable : ChipDisable;
    assign ram_raddr_o  = pc;
    assign ram_flush_o  = branch_flag_i;
    assign inst_valid_o = ~fifo_empty & ~branch_flag_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            unique case (state)
                BOOT:    state <= RUN;
                default: state <= RUN;
            endcase
            if (branch_flag_i) pc <= branch_target_i;
            else if (issue)    pc <= pc + ADDR_W'(4);
            inflight_v <= issue;
            if (issue) inflight_pc <= pc;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (ADDR_W + INST_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (branch_flag_i),
        .din   ({inflight_pc, ram_rdata_i}),
        .dout  ({inst_pc_o, inst_o}),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch with a behavioural RAM and fetch-stream model.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam int          DEPTH  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        ram_ce_o;
    logic [31:0] ram_raddr_o;
    logic        ram_flush_o;
    logic [31:0] ram_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int npop   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] next_pc = RST_PC;
    bit          boot = 1'b1;
    int          cyc = 0;

    always #5 clock = ~clock;

    inst_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ram_ce_o        (ram_ce_o),
        .ram_raddr_o     (ram_raddr_o),
        .ram_flush_o     (ram_flush_o),
        .ram_rdata_i     (ram_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_ready_i    (inst_ready_i)
    );

    // RAM contents: word i (counted from the reset PC) holds i.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a - RST_PC) >> 2;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset)                       ram_rdata_i <= '0;
        else if (ram_ce_o && !ram_flush_o) ram_rdata_i <= mem(ram_raddr_o);
        else                              ram_rdata_i <= '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / reference: every issued read is delivered in order two cycles later unless a branch flushes it.
    always @(negedge clock) begin
        bit   exp_valid, exp_pop, exp_ce;
        exp_t e;
        if (!reset) begin
            chk("rst_ce",    64'(ram_ce_o),     64'd0);
            chk("rst_raddr", 64'(ram_raddr_o),  64'(RST_PC));
            chk("rst_valid", 64'(inst_valid_o), 64'd0);
            chk("rst_inst",  64'(inst_o),       64'd0);
            chk("rst_pc",    64'(inst_pc_o),    64'd0);
            q.delete();
            next_pc = RST_PC;
            boot    = 1'b1;
        end else begin
            cyc++;
            exp_valid = !branch_flag_i && q.size() > 0 && q[0].cyc <= cyc - 2;
            chk("valid", 64'(inst_valid_o), 64'(exp_valid));
            if (exp_valid && inst_valid_o) begin
                chk("head_pc",   64'(inst_pc_o), 64'(q[0].pc));
                chk("head_inst", 64'(inst_o),    64'(q[0].inst));
            end
            exp_pop = exp_valid && inst_ready_i;
            exp_ce  = !boot && !branch_flag_i && (q.size() - int'(exp_pop) < DEPTH);
            chk("ce",    64'(ram_ce_o),    64'(exp_ce));
            chk("raddr", 64'(ram_raddr_o), 64'(next_pc));
            chk("flush", 64'(ram_flush_o), 64'(branch_flag_i));
            if (inst_valid_o && inst_ready_i) npop++;
            if (exp_pop) void'(q.pop_front());
            if (branch_flag_i) begin
                q.delete();
                next_pc = branch_target_i;
            end else if (exp_ce) begin
                e.pc = next_pc; e.inst = mem(next_pc); e.cyc = cyc;
                q.push_back(e);
                next_pc = next_pc + 32'd4;
            end
            boot = 1'b0;
        end
    end

    task automatic step(input bit rdy, input bit br, input logic [31:0] tgt);
        @(posedge clock); #1;
        inst_ready_i    = rdy;
        branch_flag_i   = br;
        branch_target_i = tgt;
    endtask

    initial begin
        logic [31:0] t;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        inst_ready_i = 1'b1;

        repeat (12) step(1, 0, 0);                 // streaming
        repeat (5)  step(0, 0, 0);                 // back-pressure
        repeat (6)  step(1, 0, 0);
        repeat (2)  step(0, 0, 0);                 // fill, then branch
        step(0, 1, 32'h1c000100);
        repeat (8)  step(1, 0, 0);
        step(1, 1, 32'h1c000180);                  // branch with pop, then re-branch
        step(1, 1, 32'h1c000200);
        repeat (8)  step(1, 0, 0);

        // asynchronous reset in the middle of a cycle
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("async_ce",    64'(ram_ce_o),     64'd0);
        chk("async_raddr", 64'(ram_raddr_o),  64'(RST_PC));
        chk("async_valid", 64'(inst_valid_o), 64'd0);
        chk("async_inst",  64'(inst_o),       64'd0);
        chk("async_pc",    64'(inst_pc_o),    64'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (6) step(1, 0, 0);

        for (int i = 0; i < 20; i++) step(i % 2 == 0, 0, 0);  // alternating ready

        step(1, 1, 32'hfffffff8);                  // PC wrap
        repeat (6) step(1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            t = $urandom();
            t[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t);
        end
        step(1, 0, 0);
        repeat (4) @(posedge clock);

        chk("pops_seen", 64'(npop > 100), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
